// File: rtl/uart_prog_loader_pkg.sv
// Shared memory-subsystem definitions: loader state encoding and word geometry.
package uart_prog_loader_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } ld_state_e;

  localparam int WORD_W         = 32;
  localparam int BYTES_PER_WORD = 4;
  localparam int IDX_W          = $clog2(BYTES_PER_WORD);

endpackage

// File: rtl/uart_prog_loader.sv
// Packs UART bytes big-endian into 32-bit words and streams them into instruction
// memory at consecutive addresses, holding the CPU until the receiver goes idle.
module uart_prog_loader
  import uart_prog_loader_pkg::*;
#(
  parameter int ADDR_WIDTH = 8,
  parameter int BASE_ADDR  = 0,
  parameter int MAX_WORDS  = 256,
  parameter bit AUTO_ARM   = 1'b1
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_start,
  input  logic [7:0]            i_rx_data,
  input  logic                  i_rx_valid,
  input  logic                  i_rx_timeout,
  output logic                  o_mem_we,
  output logic [ADDR_WIDTH-1:0] o_mem_addr,
  output logic [WORD_W-1:0]     o_mem_wdata,
  output logic                  o_cpu_hold,
  output logic                  o_load_done,
  output logic [ADDR_WIDTH:0]   o_word_count,
  output logic                  o_partial,
  output logic                  o_overflow
);

  localparam int                    PACK_W = WORD_W - 8;
  localparam ld_state_e             RST_ST = AUTO_ARM ? ST_LOAD : ST_IDLE;
  localparam logic [ADDR_WIDTH-1:0] BASE   = ADDR_WIDTH'(BASE_ADDR);
  localparam logic [ADDR_WIDTH:0]   MAXW   = (ADDR_WIDTH+1)'(MAX_WORDS);

  ld_state_e             r_state, w_next;
  logic [PACK_W-1:0]     r_pack, w_pack;
  logic [IDX_W-1:0]      r_idx, w_idx;
  logic [ADDR_WIDTH:0]   r_count;
  logic                  r_got, w_got, r_to_prev;
  logic                  w_load, w_take, w_full, w_close, w_flush;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [WORD_W-1:0]     w_flush_word;

  // A byte arriving with the timeout edge is folded in first, so the close
  // decision below looks at the post-byte index.
  assign w_load  = (r_state == ST_LOAD);
  assign w_take  = w_load && i_rx_valid && (r_count != MAXW);
  assign w_pack  = w_take ? {r_pack[PACK_W-9:0], i_rx_data} : r_pack;
  assign w_idx   = w_take ? r_idx + IDX_W'(1) : r_idx;
  assign w_full  = w_take && (r_idx == IDX_W'(BYTES_PER_WORD - 1));
  assign w_got   = r_got | (w_load & i_rx_valid);
  assign w_close = w_load && i_rx_timeout && !r_to_prev && w_got;
  assign w_flush = w_close && (w_idx != '0);
  assign w_addr  = BASE + r_count[ADDR_WIDTH-1:0];
  // Received bytes sit in the low end of the pack register; shift them to the top.
  assign w_flush_word = {w_pack, 8'h00} << (8 * (BYTES_PER_WORD - 1 - int'(w_idx)));

  always_ff @(posedge i_clk) begin
    if (i_rst) r_state <= RST_ST;
    else       r_state <= w_next;
  end

  always_comb begin
    w_next      = r_state;
    o_cpu_hold  = 1'b0;
    o_load_done = 1'b0;
    case (r_state)
      ST_IDLE:  if (i_start) w_next = ST_LOAD;
      ST_LOAD: begin
        o_cpu_hold = 1'b1;
        if (w_close) w_next = w_flush ? ST_FLUSH : ST_DONE;
      end
      ST_FLUSH: begin
        o_cpu_hold = 1'b1;
        w_next     = ST_DONE;
      end
      ST_DONE: begin
        o_load_done = 1'b1;
        w_next      = ST_IDLE;
      end
      default:  w_next = RST_ST;
    endcase
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_pack      <= '0;
      r_idx       <= '0;
      r_got       <= 1'b0;
      r_to_prev   <= 1'b0;
      r_count     <= '0;
      o_mem_we    <= 1'b0;
      o_mem_addr  <= BASE;
      o_mem_wdata <= '0;
      o_partial   <= 1'b0;
      o_overflow  <= 1'b0;
    end else begin
      r_to_prev <= i_rx_timeout;
      o_mem_we  <= 1'b0;
      if (r_state == ST_IDLE && i_start) begin
        r_pack     <= '0;
        r_idx      <= '0;
        r_got      <= 1'b0;
        r_count    <= '0;
        o_mem_addr <= BASE;
        o_partial  <= 1'b0;
        o_overflow <= 1'b0;
      end else if (w_load) begin
        r_pack <= w_pack;
        r_idx  <= w_idx;
        r_got  <= w_got;
        if (i_rx_valid && !w_take) o_overflow <= 1'b1;
        if (w_full || w_flush) begin
          o_mem_we    <= 1'b1;
          o_mem_addr  <= w_addr;
          o_mem_wdata <= w_full ? {r_pack, i_rx_data} : w_flush_word;
          r_count     <= r_count + (ADDR_WIDTH+1)'(1);
        end
        if (w_flush) o_partial <= 1'b1;
      end
    end
  end

  assign o_word_count = r_count;

endmodule
